// File: rtl/ripple_adder.sv
// ripple_adder: parameterised unsigned ripple-carry adder with carry-in,
// carry-out and a clocked sticky carry flag.
//
// Build option: define ADDER_OUT_REG_EN to register out/cout on the rising
// clk edge (one cycle of latency). When the macro is undefined, out/cout are
// purely combinational and no output flops exist. The port list is the same
// in both builds.
//
// The sticky flag always samples the combinational carry, so it reacts to the
// operands present at the edge, not to the registered carry.

module ripple_adder #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cin,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    input  logic             clr_sticky,
    output logic             cout_sticky
);

    // Carry chain: w_carry[0] is the carry-in, w_carry[WIDTH] the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH-1:0] w_sum;

    // Sticky carry state.
    logic             r_cout_sticky;

    assign w_carry[0] = cin;

    // One full-adder cell per bit; carries ripple from bit 0 upwards.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign w_prop[gi]      = lhs[gi] ^ rhs[gi];
        assign w_sum[gi]       = w_prop[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (lhs[gi] & rhs[gi]) | (w_carry[gi] & w_prop[gi]);
    end

    // Sticky flag: clear wins over set; otherwise set on any combinational carry-out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cout_sticky <= 1'b0;
        end else if (clr_sticky) begin
            r_cout_sticky <= 1'b0;
        end else if (w_carry[WIDTH]) begin
            r_cout_sticky <= 1'b1;
        end else begin
            r_cout_sticky <= r_cout_sticky;
        end
    end

    assign cout_sticky = r_cout_sticky;

`ifdef ADDER_OUT_REG_EN
    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    // Output register: sum and carry captured each edge, forced to zero in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_out  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign out  = r_out;
    assign cout = r_cout;
`else
    // Zero-latency outputs, independent of clk and reset_n.
    assign out  = w_sum;
    assign cout = w_carry[WIDTH];
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder: a WIDTH=2 and a WIDTH=8 instance share
// clock, reset and sticky clear. A driver applies operands at the falling edge
// and queues the expected response; a monitor pops and compares one entry
// shortly after each rising edge. Expected values come from integer addition.

module tb_ripple_adder;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       cin2;
    logic [1:0] lhs2;
    logic [1:0] rhs2;
    logic [1:0] out2;
    logic       cout2;
    logic       stk2;
    logic       cin8;
    logic [7:0] lhs8;
    logic [7:0] rhs8;
    logic [7:0] out8;
    logic       cout8;
    logic       stk8;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [1:0] o2;
        logic       c2;
        logic       s2;
        logic [7:0] o8;
        logic       c8;
        logic       s8;
    } exp_t;

    exp_t sb_q[$];

    // Sticky flag reference state, one per instance.
    logic m_s2;
    logic m_s8;

    ripple_adder #(.WIDTH(2)) u_dut2 (
        .clk        (clk),
        .reset_n    (rst_n),
        .cin        (cin2),
        .lhs        (lhs2),
        .rhs        (rhs2),
        .out        (out2),
        .cout       (cout2),
        .clr_sticky (clr),
        .cout_sticky(stk2)
    );

    ripple_adder #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset_n    (rst_n),
        .cin        (cin8),
        .lhs        (lhs8),
        .rhs        (rhs8),
        .out        (out8),
        .cout       (cout8),
        .clr_sticky (clr),
        .cout_sticky(stk8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Apply one vector at the falling edge and queue what the next rising edge must show.
    task automatic step(input string name, input int a2, input int b2, input int c2,
                        input int a8, input int b8, input int c8, input logic cl);
        int   sum2;
        int   sum8;
        logic k2;
        logic k8;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        clr   = cl;
        lhs2  = a2[1:0];
        rhs2  = b2[1:0];
        cin2  = c2[0];
        lhs8  = a8[7:0];
        rhs8  = b8[7:0];
        cin8  = c8[0];
        sum2  = a2 + b2 + c2;
        sum8  = a8 + b8 + c8;
        k2    = (sum2 >= 4);
        k8    = (sum8 >= 256);
        m_s2  = cl ? 1'b0 : (m_s2 | k2);
        m_s8  = cl ? 1'b0 : (m_s8 | k8);
        e.name = name;
        e.o2   = sum2[1:0];
        e.c2   = k2;
        e.s2   = m_s2;
        e.o8   = sum8[7:0];
        e.c8   = k8;
        e.s8   = m_s8;
        sb_q.push_back(e);
    endtask

    // Monitor: compare queued expectations just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, ".out2"},  {14'd0, out2},  {14'd0, e.o2});
                chk({e.name, ".cout2"}, {15'd0, cout2}, {15'd0, e.c2});
                chk({e.name, ".stk2"},  {15'd0, stk2},  {15'd0, e.s2});
                chk({e.name, ".out8"},  {8'd0, out8},   {8'd0, e.o8});
                chk({e.name, ".cout8"}, {15'd0, cout8}, {15'd0, e.c8});
                chk({e.name, ".stk8"},  {15'd0, stk8},  {15'd0, e.s8});
            end
        end
    end

    // Driver: directed cases, reset behaviour, exhaustive WIDTH=2, random WIDTH=8.
    initial begin
        int a;
        int b;
        int c;
        rst_n = 1'b0;
        clr   = 1'b0;
        cin2  = 1'b1;
        lhs2  = 2'd1;
        rhs2  = 2'd3;
        cin8  = 1'b0;
        lhs8  = 8'd0;
        rhs8  = 8'd0;
        m_s2  = 1'b0;
        m_s8  = 1'b0;
        #1;
`ifdef ADDER_OUT_REG_EN
        chk("t1ns.out2",  {14'd0, out2},  16'd0);
        chk("t1ns.cout2", {15'd0, cout2}, 16'd0);
`else
        chk("t1ns.out2",  {14'd0, out2},  16'd1);
        chk("t1ns.cout2", {15'd0, cout2}, 16'd1);
`endif
        chk("rst.stk2", {15'd0, stk2}, 16'd0);
        chk("rst.stk8", {15'd0, stk8}, 16'd0);

        step("zero",     0, 0, 0,   0,   0, 0, 1'b0);
        step("add2p1",   2, 1, 0,  17,  25, 0, 1'b0);
        step("set",      3, 3, 0, 200, 100, 0, 1'b0);
        step("hold",     0, 0, 0,   1,   2, 0, 1'b0);
        step("clrwin",   3, 3, 0, 255,   1, 0, 1'b1);
        step("wrap",     3, 3, 1, 255, 255, 1, 1'b0);
        step("reset",    3, 3, 0, 200, 100, 0, 1'b0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_s2  = 1'b0;
        m_s8  = 1'b0;
        #1;
        chk("async.stk2", {15'd0, stk2}, 16'd0);
        chk("async.stk8", {15'd0, stk8}, 16'd0);
`ifdef ADDER_OUT_REG_EN
        chk("async.out8",  {8'd0, out8},   16'd0);
        chk("async.cout8", {15'd0, cout8}, 16'd0);
`else
        chk("async.out8",  {8'd0, out8},   16'd44);
        chk("async.cout8", {15'd0, cout8}, 16'd1);
`endif

        for (int i = 0; i < 10000; i++) begin
            if (i < 32) begin
                c = (i >> 4) & 1;
                a = (i >> 2) & 3;
                b = i & 3;
            end else begin
                c = int'($urandom_range(0, 1));
                a = int'($urandom_range(0, 3));
                b = int'($urandom_range(0, 3));
            end
            step("rand", a, b, c,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(posedge clk);
        end
        #2;
        n_checks++;
        if (sb_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ripple_adder.md
Name: ripple_adder

Overview:
- Parameterised unsigned ripple-carry adder with carry-in and carry-out.
- Sum and carry are combinational by default.
- A clocked sticky carry flag records whether a carry-out has occurred since the last reset or clear.
- Used as a leaf arithmetic cell in datapaths and as the reference adder for simulator/toolchain bring-up.

Parameters:
- WIDTH, 2, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; used only by the sticky flag and the optional output register.
- reset_n  input  1  asynchronous active-low reset.
- cin  input  1  carry-in to bit 0.
- lhs  input  WIDTH  left operand, unsigned.
- rhs  input  WIDTH  right operand, unsigned.
- out  output  WIDTH  sum bits [WIDTH-1:0].
- cout  output  1  carry-out of bit WIDTH-1.
- clr_sticky  input  1  synchronous clear of cout_sticky, active-high.
- cout_sticky  output  1  set once cout has been 1 at any rising clk edge.

Behaviour:
- Arithmetic: {cout, out} = lhs + rhs + cin, computed at WIDTH+1 bits, no truncation before the carry.
- Structure: chain of WIDTH full-adder cells.
  - Bit i: s_i = lhs[i] ^ rhs[i] ^ c_i.
  - Carry: c_{i+1} = (lhs[i] & rhs[i]) | (c_i & (lhs[i] ^ rhs[i])), with c_0 = cin.
  - out[i] = s_i; cout = c_WIDTH.
- Default build: out and cout are purely combinational, with zero clock latency.
  - Outputs are valid after propagation delay, well under 1 ns in behavioural simulation.
  - Outputs are independent of clk and reset_n.
- Wrap-around: the maximum case lhs = rhs = 2^WIDTH-1 with cin=1 gives out = 2^WIDTH-1 and cout = 1.
- All operand inputs X/Z: outputs propagate X. No masking is required.
- cout_sticky register:
  - reset_n low, asynchronously: cout_sticky = 0.
  - Each rising clk edge with reset_n high:
    - clr_sticky = 1: clear to 0. Clear has priority over set on the same edge.
    - Otherwise, cout = 1: set to 1.
    - Otherwise: hold.
  - When ADDER_OUT_REG_EN is defined, the set condition samples the combinational carry, not the registered one.
- Reset asserted mid-operation: only the registered state is cleared. The combinational sum remains live.
- Reset deassertion: need not be synchronised inside the block; the parent synchronises reset_n.

Optional Feature:
- Macro: ADDER_OUT_REG_EN.
- Defined:
  - out and cout are registered on the rising clk edge, giving one cycle of latency from operand change to output.
  - reset_n low asynchronously forces out = 0 and cout = 0.
  - First valid result appears at the first rising edge after reset_n deasserts.
- Undefined:
  - Outputs are combinational as described above.
  - No output flops are instantiated.
- Port list is identical in both builds.

Test Plan:
- WIDTH=2, cin=1, lhs=1, rhs=3, no clock edge, sample at 1 ns -> out=1, cout=1.
- WIDTH=2, cin=0, lhs=0, rhs=0 -> out=0, cout=0. Then lhs=2, rhs=1 -> out=3, cout=0.
- Exhaustive sweep, WIDTH=2: all 32 combinations of cin/lhs/rhs -> {cout,out} equals the integer sum in every case. Repeat for WIDTH=8 with 10k random vectors.
- Sticky flag:
  - reset_n=0 -> cout_sticky=0.
  - Release reset, drive lhs=3, rhs=3, cin=0 (cout=1), one clk edge -> cout_sticky=1.
  - Drive cout=0 -> flag holds 1.
  - clr_sticky=1 together with cout=1 on the same edge -> cout_sticky=0.
- Async reset: assert reset_n low between clock edges while cout_sticky=1 -> cout_sticky=0 immediately, without waiting for clk.
- With ADDER_OUT_REG_EN:
  - cin=1, lhs=1, rhs=3 -> out/cout stay 0 until the next rising edge, then out=1, cout=1.
  - reset_n low -> out=0, cout=0 asynchronously.
